ble_tx_reader: RTL and testbench
================================

# ble_tx_reader

Drains BLE-bound bytes from the RAM ring buffer `[ADR_LL, ADR_UL)` and feeds them one at a time to a `uart_tx` instance. It is the reader end of the receive-path buffer writer: the writer stores one byte per 32-bit word and advances its pointer by 4; this block follows with its own read pointer. It sits in `service` beside the RAM port mux. It issues Wishbone reads only while the CPU data bus is idle, and hands each byte to the transmitter with a start/done handshake.

## Interface
Parameters:
- `BITS`, 8, width of a transmitted byte.
- `ADR_LL`, 32'h00C00000, first word address of the ring (inclusive, word aligned).
- `ADR_UL`, 32'h00C10000, end of the ring (exclusive, word aligned, `ADR_UL > ADR_LL + 4`).

Ports:
- `i_wb_clk`  in  1  system clock; the only clock.
- `i_wb_rst`  in  1  reset; synchronous, active-high.
- `i_en`  in  1  drain enable; when low, no new byte is started.
- `i_wr_adr`  in  32  writer's next-free word address, same wrap rule as `o_rd_adr`.
- `i_cpu_cyc`  in  1  CPU Wishbone cycle active.
- `o_wb_adr`  out  32  read address; equals `o_rd_adr` while `o_wb_cyc` is high.
- `o_wb_cyc`  out  1  read cycle request; when high, the top mux gives this block the RAM port.
- `o_wb_we`  out  1  constant 0.
- `o_wb_sel`  out  4  constant 4'b1111.
- `i_wb_rdt`  in  32  RAM read data.
- `i_wb_ack`  in  1  RAM acknowledge; routed here only while `o_wb_cyc` is high.
- `o_tx_dat`  out  BITS  byte to `uart_tx.i_wb_dat`.
- `o_tx_start`  out  1  one-cycle start pulse to `uart_tx.tx_active`.
- `i_tx_done`  in  1  `uart_tx.tx_done` pulse at the end of the stop bit.
- `o_rd_adr`  out  32  current read pointer.
- `o_empty`  out  1  combinational `o_rd_adr == i_wr_adr`.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, READ, START, SEND.
- IDLE -> READ when `i_en && !o_empty && !i_cpu_cyc`. Otherwise it stays in IDLE.
- READ: `o_wb_cyc` = 1 and `o_wb_adr` = `o_rd_adr`.
  - `o_wb_cyc` stays high until `i_wb_ack`, regardless of `i_cpu_cyc`.
  - On `i_wb_ack`, latch `o_tx_dat <= i_wb_rdt[BITS-1:0]` and go to START.
- START: `o_tx_start` = 1 for exactly one cycle, then go to SEND.
- SEND: wait for `i_tx_done`. On `i_tx_done`:
  - `o_rd_adr <= (o_rd_adr + 4 == ADR_UL) ? ADR_LL : o_rd_adr + 4`;
  - go to IDLE.
- `o_rd_adr` changes only on `i_tx_done` in SEND. This is the single point where a byte is consumed, so the pointer wraps exactly at `ADR_UL` and never exceeds `ADR_UL - 4`.
- `i_en` falling mid-transfer does not abort; the current byte completes and the block then holds in IDLE.
- `i_tx_done` seen outside SEND is ignored.
- `i_wb_ack` seen outside READ is ignored.
- Full/overrun detection is not done here. A writer that laps the reader makes `o_empty` true and loses that data; this is the writer's responsibility.
- Reset values:
  - FSM = IDLE;
  - `o_rd_adr` = `ADR_LL`;
  - `o_tx_dat` = 0;
  - `o_wb_cyc`, `o_tx_start`, `o_busy` = 0;
  - `o_wb_adr` = `ADR_LL`.
- A reset asserted in any state returns all of the above on the next edge. A byte in flight is dropped and the pointer is not advanced.

## Timing
- All state and outputs are registered, except `o_empty`, `o_wb_we` and `o_wb_sel`.
- Cycle 0: IDLE condition true. Cycle 1: `o_wb_cyc` high.
- With the `servant_ram` single-cycle ack, `i_wb_ack` arrives in cycle 2. Cycle 3: START (`o_tx_start` = 1, `o_tx_dat` valid). Cycle 4 onward: SEND.
- `o_tx_dat` is stable from START until the next READ ack.
- Minimum byte-to-byte overhead beyond the UART frame is 4 cycles: done -> IDLE -> READ -> ack -> START.
- If `i_cpu_cyc` and the IDLE condition are true in the same cycle, the CPU wins and the block stays in IDLE.
- If `i_tx_done` and `i_wb_rst` are asserted together, reset wins.

## Test plan
- Reset, then `i_wr_adr` = 32'h00C00008 with RAM[C00000] = 0x41 and RAM[C00004] = 0x42 -> two start pulses with `o_tx_dat` = 0x41 then 0x42; final `o_rd_adr` = 32'h00C00008 and `o_empty` = 1.
- Hold `i_cpu_cyc` = 1 for 20 cycles with data pending -> `o_wb_cyc` stays 0. After release, `o_wb_cyc` rises 1 cycle later.
- Preload `o_rd_adr` to 32'h00C0FFFC via prior transfers, with `i_wr_adr` = 32'h00C00000 -> byte read from C0FFFC, then `o_rd_adr` = 32'h00C00000.
- Drop `i_en` during SEND -> current byte completes and pointer advances once; no further READ while `i_en` = 0.
- Assert `i_wb_rst` in SEND -> next cycle FSM = IDLE, `o_rd_adr` = 32'h00C00000, `o_busy` = 0. A later `i_tx_done` pulse has no effect.
- Delay `i_wb_ack` by 3 cycles and raise `i_cpu_cyc` during READ -> `o_wb_cyc` stays high until ack; byte latched correctly.

Source files
------------

// File: rtl/ble_tx_reader.sv
`default_nettype none
// ============================================================================
// Module   : ble_tx_reader
// Brief    : Drains one byte per RAM word from a ring buffer into uart_tx,
//            reading only while the CPU leaves the data bus idle.
// Revision : 1.0 - initial release
// ============================================================================
module ble_tx_reader #(
    parameter int          BITS   = 8,
    parameter logic [31:0] ADR_LL = 32'h00C00000,
    parameter logic [31:0] ADR_UL = 32'h00C10000
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic            i_en,
    input  logic [31:0]     i_wr_adr,
    input  logic            i_cpu_cyc,
    output logic [31:0]     o_wb_adr,
    output logic            o_wb_cyc,
    output logic            o_wb_we,
    output logic [3:0]      o_wb_sel,
    input  logic [31:0]     i_wb_rdt,
    input  logic            i_wb_ack,
    output logic [BITS-1:0] o_tx_dat,
    output logic            o_tx_start,
    input  logic            i_tx_done,
    output logic [31:0]     o_rd_adr,
    output logic            o_empty,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_START = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_consume;
    logic [31:0] w_rd_adr_inc;
    logic [31:0] w_rd_adr_nxt;

    assign o_wb_we  = 1'b0;
    assign o_wb_sel = 4'b1111;
    assign o_empty  = (o_rd_adr == i_wr_adr);

    generate
        if (BITS < 32) begin : g_unused_rdt
            logic w_unused_rdt;
            assign w_unused_rdt = ^i_wb_rdt[31:BITS];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_consume   = 1'b0;
        case (r_state)
            S_IDLE:  if (i_en && !o_empty && !i_cpu_cyc) w_state_nxt = S_READ;
            S_READ:  if (i_wb_ack) w_state_nxt = S_START;
            S_START: w_state_nxt = S_SEND;
            S_SEND: begin
                if (i_tx_done) begin
                    w_state_nxt = S_IDLE;
                    w_consume   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The pointer moves only once the byte has left the transmitter.
    assign w_rd_adr_inc = o_rd_adr + 32'd4;
    assign w_rd_adr_nxt = !w_consume              ? o_rd_adr :
                          (w_rd_adr_inc == ADR_UL) ? ADR_LL   : w_rd_adr_inc;

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state    <= S_IDLE;
            o_rd_adr   <= ADR_LL;
            o_wb_adr   <= ADR_LL;
            o_tx_dat   <= '0;
            o_wb_cyc   <= 1'b0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            o_rd_adr   <= w_rd_adr_nxt;
            o_wb_adr   <= w_rd_adr_nxt;
            o_wb_cyc   <= (w_state_nxt == S_READ);
            o_tx_start <= (w_state_nxt == S_START);
            o_busy     <= (w_state_nxt != S_IDLE);
            if (r_state == S_READ && i_wb_ack)
                o_tx_dat <= i_wb_rdt[BITS-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ble_tx_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ble_tx_reader
// Brief    : Scoreboard bench for ble_tx_reader with RAM and uart_tx models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ble_tx_reader;

    localparam logic [31:0] c_ll = 32'h00C00000;
    localparam logic [31:0] c_ul = 32'h00C00010;

    logic        clk = 1'b0;
    logic        i_wb_rst, i_en, i_cpu_cyc, i_wb_ack, i_tx_done;
    logic [31:0] i_wr_adr, i_wb_rdt;
    logic [31:0] o_wb_adr, o_rd_adr;
    logic        o_wb_cyc, o_wb_we, o_tx_start, o_empty, o_busy;
    logic [3:0]  o_wb_sel;
    logic [7:0]  o_tx_dat;

    int          total = 0;
    int          bad = 0;
    int          n_starts = 0;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    int          uart_len = 2;
    bit          uart_en = 1'b1;
    logic [31:0] exp_adr_q [$];
    logic [7:0]  exp_dat_q [$];

    ble_tx_reader #(.BITS(8), .ADR_LL(c_ll), .ADR_UL(c_ul)) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (i_wb_rst),
        .i_en      (i_en),
        .i_wr_adr  (i_wr_adr),
        .i_cpu_cyc (i_cpu_cyc),
        .o_wb_adr  (o_wb_adr),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_we   (o_wb_we),
        .o_wb_sel  (o_wb_sel),
        .i_wb_rdt  (i_wb_rdt),
        .i_wb_ack  (i_wb_ack),
        .o_tx_dat  (o_tx_dat),
        .o_tx_start(o_tx_start),
        .i_tx_done (i_tx_done),
        .o_rd_adr  (o_rd_adr),
        .o_empty   (o_empty),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] adr, input logic [7:0] dat);
        exp_adr_q.push_back(adr);
        exp_dat_q.push_back(dat);
    endtask

    // RAM: word content is 0x41 + word index, with junk above the byte lane.
    initial begin
        logic [7:0] b;
        i_wb_ack = 1'b0;
        i_wb_rdt = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (i_wb_ack || !o_wb_cyc) begin
                i_wb_ack = 1'b0;
                ack_cnt  = 0;
            end else begin
                ack_cnt++;
                if (ack_cnt >= 2 + ack_delay) begin
                    b        = 8'h41 + o_wb_adr[9:2];
                    i_wb_rdt = {24'hA5A5A5, b};
                    i_wb_ack = 1'b1;
                end
            end
        end
    end

    // UART: tx_done pulse uart_len cycles after the start pulse.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start && uart_en) begin
                repeat (uart_len) @(posedge clk);
                #1 i_tx_done = 1'b1;
                @(posedge clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    // Monitor: compare read address on ack and byte on start pulse.
    always @(negedge clk) begin
        if (o_wb_cyc && i_wb_ack) begin
            if (exp_adr_q.size() == 0) chk("unexpected_read", o_wb_adr, 32'hFFFFFFFF);
            else                       chk("wb_adr", o_wb_adr, exp_adr_q.pop_front());
        end
        if (o_tx_start) begin
            n_starts++;
            if (exp_dat_q.size() == 0) chk("unexpected_start", {24'h0, o_tx_dat}, 32'hFFFFFFFF);
            else                       chk("tx_dat", {24'h0, o_tx_dat}, {24'h0, exp_dat_q.pop_front()});
        end
    end

    task automatic wait_idle(input logic [31:0] adr, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_rd_adr == adr && !o_busy) && n < 400);
        chk({name, "_rd_adr"}, o_rd_adr, adr);
        chk({name, "_busy"}, {31'h0, o_busy}, 32'h0);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_tx_start && n < 100);
        chk({name, "_start_seen"}, {31'h0, o_tx_start}, 32'h1);
    endtask

    initial begin
        int viol;
        i_wb_rst  = 1'b1;
        i_en      = 1'b0;
        i_cpu_cyc = 1'b0;
        i_wr_adr  = c_ll;
        repeat (3) tick();
        i_wb_rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_adr", o_rd_adr, c_ll);
        chk("rst_wb_adr", o_wb_adr, c_ll);
        chk("rst_ctrl", {28'h0, o_wb_cyc, o_tx_start, o_busy, o_empty}, 32'h1);
        chk("rst_tx_dat", {24'h0, o_tx_dat}, 32'h0);
        chk("wb_we_sel", {27'h0, o_wb_we, o_wb_sel}, 32'hF);

        // Two bytes pending.
        tick();
        push(32'h00C00000, 8'h41);
        push(32'h00C00004, 8'h42);
        i_en     = 1'b1;
        i_wr_adr = 32'h00C00008;
        wait_idle(32'h00C00008, "two_bytes");
        chk("two_bytes_empty", {31'h0, o_empty}, 32'h1);

        // CPU owns the bus for 20 cycles with data pending.
        tick();
        i_cpu_cyc = 1'b1;
        push(32'h00C00008, 8'h43);
        i_wr_adr = 32'h00C0000C;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_wb_cyc) viol++;
        end
        chk("cpu_hold_cyc", viol, 0);
        @(posedge clk);
        #1 i_cpu_cyc = 1'b0;
        @(negedge clk);
        chk("release_same_cycle", {31'h0, o_wb_cyc}, 32'h0);
        @(negedge clk);
        chk("release_next_cycle", {31'h0, o_wb_cyc}, 32'h1);
        wait_idle(32'h00C0000C, "cpu_release");

        // Last word of the ring, then wrap to the base.
        tick();
        push(32'h00C0000C, 8'h44);
        i_wr_adr = c_ll;
        wait_idle(c_ll, "wrap");
        chk("wrap_empty", {31'h0, o_empty}, 32'h1);

        // Enable drops mid-send: byte completes, nothing further starts.
        tick();
        uart_len = 5;
        push(32'h00C00000, 8'h41);
        i_wr_adr = 32'h00C00008;
        wait_start("en_drop");
        tick();
        i_en = 1'b0;
        wait_idle(32'h00C00004, "en_drop");
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_wb_cyc || o_busy) viol++;
        end
        chk("en_low_hold", viol, 0);
        chk("en_low_rd_adr", o_rd_adr, 32'h00C00004);
        tick();
        push(32'h00C00004, 8'h42);
        i_en = 1'b1;
        wait_idle(32'h00C00008, "en_resume");

        // Reset while in SEND drops the byte and rewinds the pointer.
        tick();
        uart_en = 1'b0;
        push(32'h00C00008, 8'h43);
        i_wr_adr = 32'h00C0000C;
        wait_start("rst_send");
        tick();
        tick();
        i_wb_rst = 1'b1;
        i_en     = 1'b0;
        tick();
        i_wb_rst = 1'b0;
        @(negedge clk);
        chk("rst_send_rd_adr", o_rd_adr, c_ll);
        chk("rst_send_wb_adr", o_wb_adr, c_ll);
        chk("rst_send_ctrl", {29'h0, o_wb_cyc, o_tx_start, o_busy}, 32'h0);
        chk("rst_send_tx_dat", {24'h0, o_tx_dat}, 32'h0);
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        @(negedge clk);
        chk("stray_done_rd_adr", o_rd_adr, c_ll);
        chk("stray_done_busy", {31'h0, o_busy}, 32'h0);

        // Slow ack with the CPU raising its cycle during READ.
        tick();
        ack_delay = 3;
        uart_len  = 2;
        uart_en   = 1'b1;
        push(32'h00C00000, 8'h41);
        push(32'h00C00004, 8'h42);
        push(32'h00C00008, 8'h43);
        i_en = 1'b1;
        viol = 0;
        do begin
            @(negedge clk);
            viol++;
        end while (!o_wb_cyc && viol < 20);
        chk("slow_cyc_seen", {31'h0, o_wb_cyc}, 32'h1);
        @(posedge clk);
        #1 i_cpu_cyc = 1'b1;
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!o_wb_cyc) viol++;
            if (i_wb_ack) break;
        end
        chk("slow_ack_seen", {31'h0, i_wb_ack}, 32'h1);
        chk("slow_cyc_held", viol, 0);
        @(posedge clk);
        #1 i_cpu_cyc = 1'b0;
        wait_idle(32'h00C0000C, "slow_ack");
        chk("slow_ack_empty", {31'h0, o_empty}, 32'h1);

        repeat (3) @(negedge clk);
        chk("start_count", n_starts, 10);
        chk("queue_drained", exp_adr_q.size() + exp_dat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
